// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared opcode and 2-bit counter constants for the branch predictor
package branch_predictor_pkg;

  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  // Saturating step of a 2-bit predictor counter toward the resolved direction
  function automatic logic [1:0] bp_sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == BP_ST) ? BP_ST : cnt + 2'd1;
    end
    return (cnt == BP_SNT) ? BP_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// rtl/bp_counter_table.sv - 2-bit saturating counter table, async read, sync saturating write
module bp_counter_table
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] ridx,
  output logic [1:0]            rdata,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] widx,
  input  logic                  taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0] cnt_q [ENTRIES];

  // No bypass: a same-cycle write to ridx is seen only from the next cycle
  assign rdata = cnt_q[ridx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BP_WNT;
      end
    end else if (we) begin
      cnt_q[widx] <= bp_sat_next(cnt_q[widx], taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare decode-stage predictor with resolve-time training and statistics
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          decode_pc,
  input  logic [31:0]          decode_inst,
  input  logic                 pred_en,
  input  logic                 result,
  output logic                 predict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] d_idx;
  logic [INDEX_BITS-1:0] e_idx;
  logic                  e_pred;
  logic [1:0]            d_cnt;
  logic                  is_branch;
  logic                  unused_bits;

  assign unused_bits = ^{decode_pc[31:INDEX_BITS+2], decode_pc[1:0],
                         decode_inst[31:7], decode_inst[1:0]};

  // History only shifts on resolved branches, so it never needs repair
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr;

      always_ff @(posedge clk) begin
        if (rst) begin
          ghr <= '0;
        end else if (pred_en) begin
          ghr <= GHR_BITS'({ghr, result});
        end
      end

      assign ghr_ext = INDEX_BITS'(ghr);
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  assign d_idx     = decode_pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign is_branch = (decode_inst[6:2] == OPC_BRANCH_5);
  assign predict   = ~rst & is_branch & d_cnt[1];

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .ridx  (d_idx),
    .rdata (d_cnt),
    .we    (pred_en),
    .widx  (e_idx),
    .taken (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      e_idx            <= '0;
      e_pred           <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      e_idx  <= d_idx;
      e_pred <= predict;
      if (pred_en) begin
        branch_count <= branch_count + CNT_WIDTH'(1);
        if (e_pred != result) begin
          mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - three-configuration predictor bench against an arithmetic reference model
module tb_branch_predictor;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] LUI  = 32'h0000_0037;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] decode_pc = 32'd0;
  logic [31:0] decode_inst = 32'd0;
  logic        pred_en = 1'b0;
  logic        result = 1'b0;

  logic        p0, p4, pw;
  logic [31:0] bc0, mc0, bc4, mc4;
  logic [3:0]  bcw, mcw;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(0), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .decode_pc(decode_pc), .decode_inst(decode_inst),
    .pred_en(pred_en), .result(result), .predict(p0),
    .branch_count(bc0), .mispredict_count(mc0));

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(4), .CNT_WIDTH(32)) u4 (
    .clk(clk), .rst(rst), .decode_pc(decode_pc), .decode_inst(decode_inst),
    .pred_en(pred_en), .result(result), .predict(p4),
    .branch_count(bc4), .mispredict_count(mc4));

  branch_predictor #(.INDEX_BITS(6), .GHR_BITS(0), .CNT_WIDTH(4)) uw (
    .clk(clk), .rst(rst), .decode_pc(decode_pc), .decode_inst(decode_inst),
    .pred_en(pred_en), .result(result), .predict(pw),
    .branch_count(bcw), .mispredict_count(mcw));

  // Reference state per instance: counters as plain ints 0..3, history as an int
  int     gb[3] = '{0, 4, 0};
  int     cw[3] = '{32, 32, 4};
  int     mt[3][64];
  int     mg[3];
  int     me_idx[3];
  int     me_pred[3];
  longint mbc[3];
  longint mmc[3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  function automatic int midx(int i);
    return int'(decode_pc[7:2]) ^ mg[i];
  endfunction

  function automatic int mpred(int i);
    if (rst || decode_inst[6:2] != 5'b11000) return 0;
    return (mt[i][midx(i)] >= 2) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int j = 0; j < 64; j++) mt[i][j] <= 1;
        mg[i]      <= 0;
        me_idx[i]  <= 0;
        me_pred[i] <= 0;
        mbc[i]     <= 0;
        mmc[i]     <= 0;
      end else begin
        if (pred_en) begin
          if (result) mt[i][me_idx[i]] <= (mt[i][me_idx[i]] == 3) ? 3 : mt[i][me_idx[i]] + 1;
          else        mt[i][me_idx[i]] <= (mt[i][me_idx[i]] == 0) ? 0 : mt[i][me_idx[i]] - 1;
          mg[i]  <= ((mg[i] << 1) | int'(result)) & ((1 << gb[i]) - 1);
          mbc[i] <= (mbc[i] + 1) & ((64'sd1 << cw[i]) - 1);
          mmc[i] <= (mmc[i] + ((me_pred[i] != int'(result)) ? 1 : 0)) & ((64'sd1 << cw[i]) - 1);
        end
        me_idx[i]  <= midx(i);
        me_pred[i] <= mpred(i);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0.predict", longint'(p0), longint'(mpred(0)));
      chk("u0.branch_count", longint'(bc0), mbc[0]);
      chk("u0.mispredict_count", longint'(mc0), mmc[0]);
      chk("u4.predict", longint'(p4), longint'(mpred(1)));
      chk("u4.branch_count", longint'(bc4), mbc[1]);
      chk("u4.mispredict_count", longint'(mc4), mmc[1]);
      chk("uw.predict", longint'(pw), longint'(mpred(2)));
      chk("uw.branch_count", longint'(bcw), mbc[2]);
      chk("uw.mispredict_count", longint'(mcw), mmc[2]);
    end
  end

  task automatic cyc(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                     input logic pe, input logic res);
    @(posedge clk);
    #1;
    rst         = r;
    decode_pc   = pc;
    decode_inst = inst;
    pred_en     = pe;
    result      = res;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 32'h0, ADDI, 0, 0);

    // Reset state and non-branch opcode
    cyc(0, 32'h100, LUI, 0, 0);
    chk_on = 1'b1;
    chk("t1 lui predict", longint'(p0), 0);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t1 beq wnt predict", longint'(p0), 0);
    chk("t1 branch_count", longint'(bc0), 0);
    chk("t1 mispredict_count", longint'(mc0), 0);

    // Two taken resolutions of PC 0x100, spaced so the second is decoded after the first update
    cyc(0, 32'h100, ADDI, 1, 1);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t2 predict after first update", longint'(p0), 1);
    cyc(0, 32'h100, ADDI, 1, 1);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t2 predict strongly taken", longint'(p0), 1);
    chk("t2 branch_count", longint'(bc0), 2);
    chk("t2 mispredict_count", longint'(mc0), 1);
    chk("t2 model entry 0x100", longint'(mt[0][0]), 3);

    // Saturation at both ends
    for (int k = 0; k < 4; k++) cyc(0, 32'h100, BEQ, 1, 0);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t3 floor holds at 00", longint'(p0), 0);
    cyc(0, 32'h100, BEQ, 1, 1);
    cyc(0, 32'h100, BEQ, 1, 1);
    chk("t3 01 after one inc", longint'(p0), 0);
    cyc(0, 32'h100, BEQ, 1, 1);
    chk("t3 10 after two inc", longint'(p0), 1);
    cyc(0, 32'h100, BEQ, 1, 1);
    cyc(0, 32'h100, BEQ, 1, 1);
    cyc(0, 32'h100, BEQ, 0, 0);
    cyc(0, 32'h100, BEQ, 1, 0);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t3 ceiling held at 11", longint'(p0), 1);

    // Same-cycle read and write of one entry
    cyc(0, 32'h104, BEQ, 0, 0);
    cyc(0, 32'h104, BEQ, 1, 1);
    chk("t4 conflict reads old value", longint'(p0), 0);
    cyc(0, 32'h104, BEQ, 0, 0);
    chk("t4 new value next cycle", longint'(p0), 1);

    // Gshare history T,N,T,T
    cyc(1, 32'h0, ADDI, 0, 0);
    cyc(0, 32'h200, BEQ, 0, 0);
    cyc(0, 32'h200, BEQ, 1, 1);
    cyc(0, 32'h200, BEQ, 1, 0);
    cyc(0, 32'h200, BEQ, 1, 1);
    cyc(0, 32'h200, BEQ, 1, 1);
    cyc(0, 32'h0, BEQ, 0, 0);
    chk("t5 model ghr", longint'(mg[1]), 11);
    chk("t5 entry 11 still wnt", longint'(p4), 0);
    cyc(0, 32'h0, ADDI, 1, 1);
    cyc(0, 32'h30, BEQ, 0, 0);
    chk("t5 model entry 11", longint'(mt[1][11]), 2);
    chk("t5 entry 11 trained", longint'(p4), 1);
    cyc(0, 32'h1c, BEQ, 0, 0);
    chk("t5 entry 0 unchanged", longint'(p4), 0);

    // Reset in the middle of back-to-back resolutions
    for (int k = 0; k < 3; k++) cyc(0, 32'h100, BEQ, 1, 1);
    cyc(1, 32'h100, BEQ, 1, 1);
    chk("t6 predict forced low in reset", longint'(p0), 0);
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t6 branch_count cleared", longint'(bc0), 0);
    chk("t6 mispredict_count cleared", longint'(mc0), 0);
    chk("t6 gshare branch_count cleared", longint'(bc4), 0);
    for (int j = 0; j < 64; j++) begin
      cyc(0, 32'(j) << 2, BEQ, 0, 0);
      chk("t6 entry wnt bimodal", longint'(p0), 0);
      chk("t6 entry wnt gshare", longint'(p4), 0);
    end

    // Counter wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) cyc(0, 32'h100, BEQ, 1, 1'(k % 2));
    cyc(0, 32'h100, BEQ, 0, 0);
    chk("t6 wrapped branch_count", longint'(bcw), 1);
    chk("t6 full branch_count", longint'(bc0), 17);

    // Mixed traffic checked only against the model
    for (int k = 0; k < 80; k++) begin
      cyc(1'($urandom_range(0, 29) == 0), 32'($urandom_range(0, 15)) << 2,
          ($urandom_range(0, 3) == 0) ? ADDI : BEQ,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
